// File: rtl/instruction_loader_if.sv
// Byte-stream in / instruction-memory write port out, for the boot loader.
//   master : host side (drives start/len_words/byte stream, observes status)
//   slave  : loader side
// Signals: start, len_words, byte_in, byte_valid, byte_ready,
//          mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err, checksum
interface instruction_loader_if #(
  parameter int LEN_W = 11
);
  logic             start;
  logic [LEN_W-1:0] len_words;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             cpu_rst;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      checksum;

  modport master (
    output start, len_words, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err, checksum
  );

  modport slave (
    input  start, len_words, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err, checksum
  );
endinterface

// File: rtl/instruction_loader.sv
// Boot-time instruction memory writer. Packs a byte stream little-endian
// into 32-bit words, writes them to consecutive word addresses and keeps
// the core in reset (cpu_rst) until the full program has been written.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - instruction_loader_if.slave: start/len_words command, byte
//          stream (byte_in/byte_valid/byte_ready), memory write port
//          (mem_we/mem_addr/mem_wdata) and status (cpu_rst/busy/done/
//          err/checksum). All outputs are registered.
module instruction_loader #(
  parameter int DEPTH = 1024,
  parameter int LEN_W = 11
) (
  input logic               clk,
  input logic               rst,
  instruction_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_idx;
  logic [LEN_W-1:0] word_nxt;
  logic [1:0]       byte_cnt;
  // Holds bytes 0..2 of the word; mem_wdata only changes when a word completes.
  logic [23:0]      wbuf;

  assign word_nxt = word_idx + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      len_q          <= '0;
      word_idx       <= '0;
      byte_cnt       <= '0;
      wbuf           <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.cpu_rst    <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.checksum   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // byte_ready is low here, so a concurrent byte_valid is left pending.
          if (bus.start) begin
            if (bus.len_words > LEN_W'(DEPTH)) begin
              bus.err <= 1'b1;
            end else begin
              len_q        <= bus.len_words;
              word_idx     <= '0;
              byte_cnt     <= '0;
              bus.checksum <= '0;
              bus.err      <= 1'b0;
              if (bus.len_words == '0) begin
                state       <= DONE;
                bus.done    <= 1'b1;
                bus.cpu_rst <= 1'b0;
              end else begin
                state          <= RECV;
                bus.done       <= 1'b0;
                bus.cpu_rst    <= 1'b1;
                bus.busy       <= 1'b1;
                bus.byte_ready <= 1'b1;
              end
            end
          end
        end

        RECV: begin
          if (bus.byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: wbuf[7:0]   <= bus.byte_in;
              2'd1: wbuf[15:8]  <= bus.byte_in;
              2'd2: wbuf[23:16] <= bus.byte_in;
              default: begin
                // Fourth byte: present the word and pulse the write next cycle.
                bus.mem_wdata  <= {bus.byte_in, wbuf};
                bus.mem_addr   <= {{(30-LEN_W){1'b0}}, word_idx, 2'b00};
                bus.mem_we     <= 1'b1;
                bus.byte_ready <= 1'b0;
                state          <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          bus.mem_we   <= 1'b0;
          bus.checksum <= bus.checksum ^ bus.mem_wdata;
          word_idx     <= word_nxt;
          if (word_nxt == len_q) begin
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.cpu_rst <= 1'b0;
            bus.busy    <= 1'b0;
          end else begin
            state          <= RECV;
            bus.byte_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   wcount = 0;

  instruction_loader_if #(.LEN_W(11)) bus ();

  instruction_loader #(.DEPTH(1024), .LEN_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Count write pulses as seen at each rising edge.
  always @(posedge clk) if (bus.mem_we) wcount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with start low again.
  task automatic do_start(input logic [10:0] len);
    bus.start = 1'b1;
    bus.len_words = len;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  // Sends a word LSB first; optional idle cycle between bytes.
  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) check("we_early", 32'(bus.mem_we), 32'd0);
      send_byte(w[8*k +: 8]);
      if (k < 3 && gap) @(negedge clk);
    end
    check("we_pulse", 32'(bus.mem_we), 32'd1);
    check("wr_addr", bus.mem_addr, addr);
    check("wr_data", bus.mem_wdata, w);
    @(negedge clk);
    check("we_one_cycle", 32'(bus.mem_we), 32'd0);
  endtask

  initial begin
    logic [31:0] xs;
    int w0;
    bus.start = 1'b0;
    bus.len_words = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_checksum", bus.checksum, 32'd0);

    // Two-word load, back-to-back bytes; start wins over a concurrent byte
    bus.byte_valid = 1'b1;
    bus.byte_in = 8'hFF;
    do_start(11'd2);
    bus.byte_valid = 1'b0;
    check("busy_recv", 32'(bus.busy), 32'd1);
    check("ready_recv", 32'(bus.byte_ready), 32'd1);
    check("cpu_rst_load", 32'(bus.cpu_rst), 32'd1);
    send_word(32'hE3A00014, 32'd0, 1'b0);
    send_word(32'hE3A01A01, 32'd4, 1'b0);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check("t2_busy", 32'(bus.busy), 32'd0);
    check("t2_checksum", bus.checksum, 32'h00001A15);
    check("t2_wcount", 32'(wcount), 32'd2);

    // Same load with byte_valid toggling
    do_start(11'd2);
    check("t3_done_clr", 32'(bus.done), 32'd0);
    check("t3_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    send_word(32'hE3A00014, 32'd0, 1'b1);
    send_word(32'hE3A01A01, 32'd4, 1'b1);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_checksum", bus.checksum, 32'h00001A15);

    // Zero-length and oversize loads
    w0 = wcount;
    do_start(11'd0);
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_checksum", bus.checksum, 32'd0);
    do_start(11'd1025);
    check("t4_err", 32'(bus.err), 32'd1);
    check("t4_err_ready", 32'(bus.byte_ready), 32'd0);
    check("t4_err_busy", 32'(bus.busy), 32'd0);
    check("t4_err_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    repeat (2) @(negedge clk);
    check("t4_wcount", 32'(wcount - w0), 32'd0);

    // Async reset mid-word, then a fresh one-word load
    do_start(11'd4);
    check("t5_err_clr", 32'(bus.err), 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    check("t5_ready", 32'(bus.byte_ready), 32'd0);
    check("t5_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_addr", bus.mem_addr, 32'd0);
    check("t5_wdata", bus.mem_wdata, 32'd0);
    check("t5_checksum", bus.checksum, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(11'd1);
    send_word(32'h12345678, 32'd0, 1'b0);
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_sum", bus.checksum, 32'h12345678);

    // Full-depth load with a stray start during RECV
    do_start(11'd1024);
    xs = '0;
    for (int w = 0; w < 1024; w++) begin
      logic [31:0] d;
      d = {8'hA5, 8'(w * 7), 16'(w)};
      xs ^= d;
      if (w == 3) begin
        send_byte(d[7:0]);
        do_start(11'd2);
        send_byte(d[15:8]);
        send_byte(d[23:16]);
        check("t6_busy_after_start", 32'(bus.busy), 32'd1);
        send_byte(d[31:24]);
        check("t6_w3_addr", bus.mem_addr, 32'd12);
        check("t6_w3_data", bus.mem_wdata, d);
        @(negedge clk);
      end else begin
        send_word(d, 32'(w) << 2, 1'b0);
      end
    end
    check("t6_last_addr", bus.mem_addr, 32'h00000FFC);
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check("t6_checksum", bus.checksum, xs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
